// File: rtl/alu_phase_sequencer.sv
// Sequences one ALU operation at a time through the 17-phase adiabatic datapath:
// opcode decode, one-hot phase walk, capture strobes, zero sampling and response handshake.
module alu_phase_sequencer #(
    parameter int unsigned NPHASE     = 17,
    parameter int unsigned ZERO_PHASE = 10,
    parameter int unsigned OUT_PHASE  = 14,
    parameter int unsigned OPW        = 4
) (
    input  logic              clkpos,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OPW-1:0]    req_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_zero,
    output logic              resp_err,
    input  logic              zero_in,
    output logic [NPHASE-1:0] phase_en,
    output logic              a_fclk,
    output logic              alu_o_fclk,
    output logic [1:0]        alu_ctrl,
    output logic              sub,
    output logic              stl,
    output logic              adder_cin,
    output logic [1:0]        b_sel,
    output logic              a_sel,
    output logic [1:0]        out_sel
);

    localparam int unsigned PW = $clog2(NPHASE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [1:0] alu_ctrl;
        logic       sub;
        logic       stl;
        logic       adder_cin;
        logic [1:0] b_sel;
        logic       a_sel;
        logic [1:0] out_sel;
    } ctrl_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_nxt;
    logic          w_accept;
    logic          w_last_phase;
    logic          w_run_legal;
    ctrl_t         w_dec;
    logic          w_dec_illegal;
    ctrl_t         r_ctrl;
    logic          r_illegal;
    logic          r_zero;

    assign w_last_phase = (r_phase == PW'(NPHASE - 1));

    // Opcode decode; anything outside 0..7 yields all-zero controls and the error flag.
    always_comb begin
        w_dec         = '0;
        w_dec_illegal = 1'b0;
        case (req_op)
            OPW'(0): w_dec = '{alu_ctrl: 2'b10, sub: 1'b0, stl: 1'b0, adder_cin: 1'b0,
                               b_sel: 2'b11, a_sel: 1'b1, out_sel: 2'b01};
            OPW'(1): w_dec = '{alu_ctrl: 2'b10, sub: 1'b1, stl: 1'b0, adder_cin: 1'b1,
                               b_sel: 2'b11, a_sel: 1'b1, out_sel: 2'b01};
            OPW'(2): w_dec = '{alu_ctrl: 2'b00, sub: 1'b0, stl: 1'b0, adder_cin: 1'b0,
                               b_sel: 2'b11, a_sel: 1'b1, out_sel: 2'b01};
            OPW'(3): w_dec = '{alu_ctrl: 2'b01, sub: 1'b0, stl: 1'b0, adder_cin: 1'b0,
                               b_sel: 2'b11, a_sel: 1'b1, out_sel: 2'b01};
            OPW'(4): w_dec = '{alu_ctrl: 2'b11, sub: 1'b0, stl: 1'b1, adder_cin: 1'b1,
                               b_sel: 2'b11, a_sel: 1'b1, out_sel: 2'b01};
            OPW'(5): w_dec = '{alu_ctrl: 2'b10, sub: 1'b0, stl: 1'b0, adder_cin: 1'b0,
                               b_sel: 2'b01, a_sel: 1'b1, out_sel: 2'b01};
            OPW'(6): w_dec = '{alu_ctrl: 2'b10, sub: 1'b0, stl: 1'b0, adder_cin: 1'b0,
                               b_sel: 2'b10, a_sel: 1'b0, out_sel: 2'b01};
            OPW'(7): w_dec = '{alu_ctrl: 2'b10, sub: 1'b1, stl: 1'b0, adder_cin: 1'b1,
                               b_sel: 2'b11, a_sel: 1'b1, out_sel: 2'b10};
            default: w_dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clkpos or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // flush overrides both the accept and the normal progression.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        req_ready   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: req_ready = 1'b1;
            ST_RUN: begin
                if (w_last_phase) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_phase_nxt = r_phase + PW'(1);
                end
            end
            ST_DONE: begin
                req_ready = resp_ready;
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            req_ready = 1'b0;
        end
        w_accept = req_valid && req_ready;
        if (w_accept) begin
            w_state_nxt = ST_RUN;
            w_phase_nxt = '0;
        end
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clkpos or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
            r_zero    <= 1'b0;
        end else if (!flush) begin
            if (w_accept) begin
                r_ctrl    <= w_dec;
                r_illegal <= w_dec_illegal;
                r_zero    <= 1'b0;
            end else if (r_state == ST_RUN && r_phase == PW'(ZERO_PHASE)) begin
                r_zero <= zero_in;
            end
        end
    end

    assign w_run_legal = (r_state == ST_RUN) && !r_illegal;

    always_comb begin
        phase_en   = '0;
        a_fclk     = 1'b0;
        alu_o_fclk = 1'b0;
        if (w_run_legal) begin
            phase_en   = NPHASE'(1) << r_phase;
            a_fclk     = (r_phase == '0);
            alu_o_fclk = (r_phase == PW'(OUT_PHASE));
        end
    end

    assign resp_valid = (r_state == ST_DONE);
    assign resp_zero  = r_zero;
    assign resp_err   = r_illegal;
    assign alu_ctrl   = r_ctrl.alu_ctrl;
    assign sub        = r_ctrl.sub;
    assign stl        = r_ctrl.stl;
    assign adder_cin  = r_ctrl.adder_cin;
    assign b_sel      = r_ctrl.b_sel;
    assign a_sel      = r_ctrl.a_sel;
    assign out_sel    = r_ctrl.out_sel;

endmodule

// File: doc/alu_phase_sequencer.md
Name: alu_phase_sequencer

Overview:
Digital controller that sequences one operation at a time through the 17-phase adiabatic ALU datapath. It accepts an opcode over a valid/ready handshake, decodes it into the ALU static control fields, and walks a one-hot phase enable across the clkpos/clkneg stage ordering 0..16. It strobes the operand and result register captures, samples the zero detector, and returns a completion response with its own handshake.

Parameters:
NPHASE, 17, number of pipeline phases; phase indices 0..NPHASE-1
ZERO_PHASE, 10, phase at whose final cycle zero_in is sampled
OUT_PHASE, 14, phase in which the result register capture strobe fires
OPW, 4, opcode width

Ports:
clkpos  input  1  sequencer clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort to IDLE
req_valid  input  1  operation request
req_ready  output  1  request accepted when valid&&ready
req_op  input  OPW  opcode
resp_valid  output  1  operation complete
resp_ready  input  1  consumer accepts response
resp_zero  output  1  zero flag of completed op
resp_err  output  1  completed op was illegal
zero_in  input  1  zero detector output
phase_en  output  NPHASE  one-hot active phase, bit i maps to stage i
a_fclk  output  1  operand register capture strobe
alu_o_fclk  output  1  result register capture strobe
alu_ctrl  output  2  result mux select: 00 AND, 01 OR, 10 adder, 11 carry-out
sub  output  1  invert the first adder operand
stl  output  1  invert the second adder operand
adder_cin  output  1  adder carry in
b_sel  output  2  first-operand mux: 00 instr>>1, 01 instr, 10 const 2, 11 SRAM
a_sel  output  1  second-operand mux: 0 PC, 1 register B
out_sel  output  2  output mux: 00 instr>>1, 01 alu_out, 10 alu_muxout

Behaviour:
- Reset values: state is IDLE. All outputs are 0, except req_ready, which is 1.
- States:
  - IDLE: req_ready=1. A handshake latches the decoded controls and the illegal flag, sets phase to 0, and moves to RUN.
  - RUN: phase_en = 1<<phase, one phase per cycle. After phase NPHASE-1 the state moves to DONE.
  - DONE: resp_valid=1 and phase_en=0. resp_valid&&resp_ready moves the state to IDLE.
- req_ready = (IDLE) || (DONE && resp_ready). A new request accepted in DONE goes straight to RUN at phase 0, with no idle bubble.
- Latency: request accept edge to resp_valid is NPHASE+1 cycles. The minimum back-to-back spacing is NPHASE+1 cycles.
- Strobes (combinational from state and phase):
  - a_fclk=1 during phase 0.
  - alu_o_fclk=1 during OUT_PHASE.
- Zero flag: zero_in is registered on the clock edge that ends ZERO_PHASE and is held in resp_zero until the next accept.
- Control fields are registered at accept and stay constant through RUN and DONE. They change only on the next accept.
- Decode (fields given as alu_ctrl, sub, stl, adder_cin, b_sel, a_sel, out_sel):
  - 0 ADD: 10,0,0,0,11,1,01
  - 1 SUB: 10,1,0,1,11,1,01
  - 2 AND: 00,0,0,0,11,1,01
  - 3 OR: 01,0,0,0,11,1,01
  - 4 SLT: 11,0,1,1,11,1,01
  - 5 ADDI: 10,0,0,0,01,1,01
  - 6 PCINC: 10,0,0,0,10,0,01
  - 7 BEQ: 10,1,0,1,11,1,10
- Illegal opcodes 8..15: the op is accepted, all control fields are 0, and the sequence still runs. phase_en and both strobes stay 0 throughout. resp_err=1 at DONE.
- flush: has priority over everything else.
  - Goes to IDLE next cycle and clears phase_en and resp_valid.
  - A request presented in the same cycle is not accepted (req_ready is forced to 0 while flush=1).
  - resp_zero, resp_err and the control fields hold their values.
- Reset mid-RUN: all outputs return to their reset values immediately (asynchronously). No strobe is emitted after reset asserts.
- Invariants:
  - phase_en is always one-hot or zero, never multi-hot.
  - In RUN, phase wraps only through DONE and never 16 back to 0.

Test Plan:
- Reset, then ADD (op 0) accepted at cycle 0.
  - phase_en=1<<k in cycles 1..17, with a_fclk at cycle 1 and alu_o_fclk at cycle 15.
  - resp_valid at cycle 18; controls read 10,0,0,0,11,1,01.
- SUB with zero_in=1 only in the phase-10 cycle -> resp_zero=1. Repeat with zero_in=1 in every phase except phase 10 -> resp_zero=0.
- resp_ready held 0 for 5 cycles in DONE -> resp_valid and resp_zero hold and phase_en=0. Then resp_ready=1 together with req_valid=1 carrying AND -> the new op is at phase 0 on the next cycle and alu_ctrl=00.
- Opcode 12 -> full sequence runs with phase_en=0, no strobes, resp_err=1 and all controls 0.
- flush at phase 7 while req_valid=1 -> IDLE next cycle, phase_en=0, no alu_o_fclk, and the request is not accepted.
- rst_n asserted during phase 5 -> phase_en=0 and req_ready=1 asynchronously. After release, PCINC runs normally with b_sel=10 and a_sel=0.
